// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_NOT  = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_PASS = 4'h3;
  localparam logic [3:0] ALU_SUB  = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_SHL  = 4'h7;
  localparam logic [3:0] ALU_SHR  = 4'h8;
  localparam logic [3:0] ALU_SETC = 4'h9;
  localparam logic [3:0] ALU_CLRC = 4'hA;
  localparam logic [3:0] ALU_INC  = 4'hB;
  localparam logic [3:0] ALU_DEC  = 4'hC;
  localparam logic [3:0] ALU_MUL  = 4'hD;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic {IDLE, BUSY} alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH iterations per product.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_step;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     sum;

  // Upper half accumulates; lower half holds the remaining multiplier bits.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step = {sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= CntW'(WIDTH - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (flush_i) begin
        busy_q <= 1'b0;
      end else begin
        prod_q <= prod_step;
        cnt_q  <= cnt_q - CntW'(1);
        if (cnt_q == '0) busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0) && !flush_i;
  assign prod_o = prod_step;

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with {N,C,Z} flag register and a stalling multi-cycle MUL.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter bit          MUL_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flag_load,
  input  logic [2:0]       flag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flag
);

  logic [WIDTH-1:0]   out_q, out_d;
  logic [2:0]         flag_q, flag_d;
  logic               out_valid_q, out_valid_d;
  alu_state_t         state_q, state_d;

  logic               accept, is_mul;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2:0]         mul_flag;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   res;
  logic [2:0]         op_flag;
  logic               c_new, op_wr, op_out;

  assign accept = in_valid & in_ready & ~flush;
  assign is_mul = MUL_EN && (aluControl == ALU_MUL);
  assign sh     = in2[SHAMT_W-1:0];

  if (MUL_EN) begin : g_mul
    alu_seq_mul #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .start_i(accept & is_mul),
      .flush_i(flush),
      .a_i    (in1),
      .b_i    (in2),
      .busy_o (mul_busy),
      .done_o (mul_done),
      .prod_o (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Single-cycle result mux; op_wr marks ops that write out, op_out ops that pulse out_valid.
  always_comb begin
    ext    = '0;
    res    = out_q;
    c_new  = flag_q[FLAG_C];
    op_wr  = 1'b0;
    op_out = 1'b1;
    case (aluControl)
      ALU_NOT:  begin res = ~in2;       op_wr = 1'b1; end
      ALU_PASS: begin res = in1;        op_wr = 1'b1; end
      ALU_AND:  begin res = in1 & in2;  op_wr = 1'b1; end
      ALU_OR:   begin res = in1 | in2;  op_wr = 1'b1; end
      ALU_ADD: begin
        ext = {1'b0, in1} + {1'b0, in2};
        {c_new, res} = ext;
        op_wr = 1'b1;
      end
      ALU_SUB: begin
        ext = {1'b0, in1} - {1'b0, in2};
        {c_new, res} = ext;
        op_wr = 1'b1;
      end
      ALU_INC: begin
        ext = {1'b0, in1} + (WIDTH+1)'(1);
        {c_new, res} = ext;
        op_wr = 1'b1;
      end
      ALU_DEC: begin
        ext = {1'b0, in1} - (WIDTH+1)'(1);
        {c_new, res} = ext;
        op_wr = 1'b1;
      end
      ALU_SHL: begin
        op_wr = 1'b1;
        res   = in1;
        if (sh != '0) begin
          ext = {1'b0, in1} << sh;
          {c_new, res} = ext;
        end
      end
      ALU_SHR: begin
        op_wr = 1'b1;
        res   = in1;
        if (sh != '0) begin
          ext = {in1, 1'b0} >> sh;
          {res, c_new} = ext;
        end
      end
      ALU_SETC: c_new = 1'b1;
      ALU_CLRC: c_new = 1'b0;
      default:  op_out = 1'b0;
    endcase
    op_flag         = flag_q;
    op_flag[FLAG_C] = c_new;
    if (op_wr) begin
      op_flag[FLAG_N] = res[WIDTH-1];
      op_flag[FLAG_Z] = (res == '0);
    end
  end

  always_comb begin
    mul_flag         = '0;
    mul_flag[FLAG_N] = mul_prod[WIDTH-1];
    mul_flag[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flag[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
  end

  always_comb begin
    out_d       = out_q;
    flag_d      = flag_q;
    out_valid_d = 1'b0;
    if (accept && op_out) begin
      if (op_wr) out_d = res;
      flag_d      = op_flag;
      out_valid_d = 1'b1;
    end
    if (mul_busy && mul_done) begin
      out_d       = mul_prod[WIDTH-1:0];
      flag_d      = mul_flag;
      out_valid_d = 1'b1;
    end
    // Restored flags win over any op flag update in the same edge.
    if (flag_load) flag_d = flag_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = BUSY;
      BUSY:    if (flush || mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign flag      = flag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vector table, multi-cycle corner sequences, random ops.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        flag_load = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [2:0]  flag_in = '0;
  logic        in_ready, out_valid;
  logic [15:0] out;
  logic [2:0]  flag;

  int checks = 0;
  int errors = 0;

  alu_pipe #(
    .WIDTH  (16),
    .SHAMT_W(4),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluControl(op),
    .in1       (in1),
    .in2       (in2),
    .flag_load (flag_load),
    .flag_in   (flag_in),
    .out_valid (out_valid),
    .out       (out),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        fl_load;
    logic [2:0]  fl_in;
    logic [15:0] e_out;
    logic [2:0]  e_flag;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: result of one op from the arithmetic rules, with C/N/Z from whole-number maths.
  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] fl, input logic [15:0] prev,
                                output logic v, output logic [15:0] r, output logic [2:0] f);
    logic [31:0] ua, ub, s;
    longint unsigned p;
    int unsigned sh;
    logic c, wr;
    ua = {16'h0, a};
    ub = {16'h0, b};
    sh = b % 16;
    c  = fl[1];
    wr = 1'b1;
    v  = 1'b1;
    r  = prev;
    case (o)
      4'h1: r = ~b;
      4'h2: begin s = ua + ub; r = s[15:0]; c = (s > 32'd65535); end
      4'h3: r = a;
      4'h4: begin s = ua - ub; r = s[15:0]; c = (ua < ub); end
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: begin
        s = ua << sh; r = s[15:0];
        if (sh != 0) c = s[16];
      end
      4'h8: begin
        s = ua >> sh; r = s[15:0];
        if (sh != 0) begin s = ua >> (sh - 1); c = s[0]; end
      end
      4'h9: begin wr = 1'b0; c = 1'b1; end
      4'hA: begin wr = 1'b0; c = 1'b0; end
      4'hB: begin s = ua + 1; r = s[15:0]; c = (ua == 32'd65535); end
      4'hC: begin s = ua - 1; r = s[15:0]; c = (ua == 0); end
      4'hD: begin p = longint'(ua) * longint'(ub); r = p[15:0]; c = ((p >> 16) != 0); end
      default: begin v = 1'b0; wr = 1'b0; end
    endcase
    f = {wr ? r[15] : fl[2], v ? c : fl[1], wr ? (r == 16'h0) : fl[0]};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
  endtask

  initial begin
    logic        v;
    logic [15:0] r, exp_out;
    logic [2:0]  f, exp_flag;

    // {N,C,Z} carried from one row to the next.
    vecs.push_back('{4'h2, 16'hFFFF, 16'h0001, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b1});
    vecs.push_back('{4'h1, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'hFFFF, 3'b110, 1'b1});
    vecs.push_back('{4'h4, 16'h0003, 16'h0005, 1'b0, 3'b000, 16'hFFFE, 3'b110, 1'b1});
    vecs.push_back('{4'h7, 16'h8001, 16'h0001, 1'b0, 3'b000, 16'h0002, 3'b010, 1'b1});
    vecs.push_back('{4'h8, 16'h1234, 16'h0000, 1'b0, 3'b000, 16'h1234, 3'b010, 1'b1});
    vecs.push_back('{4'hA, 16'h5555, 16'h5555, 1'b0, 3'b000, 16'h1234, 3'b000, 1'b1});
    vecs.push_back('{4'h8, 16'h0003, 16'h0001, 1'b0, 3'b000, 16'h0001, 3'b010, 1'b1});
    vecs.push_back('{4'h5, 16'hF0F0, 16'h0F0F, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b1});
    vecs.push_back('{4'h6, 16'h8000, 16'h0001, 1'b0, 3'b000, 16'h8001, 3'b110, 1'b1});
    vecs.push_back('{4'hB, 16'hFFFF, 16'h0000, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b1});
    vecs.push_back('{4'hC, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'hFFFF, 3'b110, 1'b1});
    vecs.push_back('{4'h3, 16'h0000, 16'h1111, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b1});
    vecs.push_back('{4'h0, 16'h1234, 16'h1234, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b0});
    vecs.push_back('{4'hA, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h0000, 3'b001, 1'b1});
    vecs.push_back('{4'h9, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h0000, 3'b011, 1'b1});
    vecs.push_back('{4'h2, 16'h0001, 16'h0001, 1'b1, 3'b101, 16'h0002, 3'b101, 1'b1});
    vecs.push_back('{4'hE, 16'h7777, 16'h7777, 1'b0, 3'b000, 16'h0002, 3'b101, 1'b0});
    vecs.push_back('{4'h0, 16'h0000, 16'h0000, 1'b1, 3'b010, 16'h0002, 3'b010, 1'b0});
    vecs.push_back('{4'h4, 16'h0005, 16'h0005, 1'b0, 3'b000, 16'h0000, 3'b001, 1'b1});
    vecs.push_back('{4'h2, 16'h7FFF, 16'h0001, 1'b0, 3'b000, 16'h8000, 3'b100, 1'b1});

    #1;
    chk("reset_out", out, 16'h0);
    chk("reset_flag", flag, 3'b000);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      flag_load = vecs[i].fl_load;
      flag_in   = vecs[i].fl_in;
      tick();
      in_valid  = 1'b0;
      flag_load = 1'b0;
      chk($sformatf("vec%0d_out", i), out, vecs[i].e_out);
      chk($sformatf("vec%0d_flag", i), flag, vecs[i].e_flag);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
    end
    tick();
    chk("pulse_drop", out_valid, 1'b0);

    // MUL 0100*0100 with a following ADD held off until completion.
    issue(4'hD, 16'h0100, 16'h0100);
    tick();
    issue(4'h2, 16'h0001, 16'h0002);
    chk("mul_ready_e0", in_ready, 1'b0);
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk($sformatf("mul_ready_%0d", j), in_ready, 1'b0);
      chk($sformatf("mul_novalid_%0d", j), out_valid, 1'b0);
    end
    tick();
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_out", out, 16'h0000);
    chk("mul_flag", flag, 3'b011);
    chk("mul_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("held_add_valid", out_valid, 1'b1);
    chk("held_add_out", out, 16'h0003);
    chk("held_add_flag", flag, 3'b000);

    // flush while idle blocks the accept
    issue(4'h2, 16'h0010, 16'h0010);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_valid", out_valid, 1'b0);
    chk("idle_flush_out", out, 16'h0003);

    // flush at E0+7 of a MUL
    issue(4'hD, 16'hFFFF, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 6; j++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_out", out, 16'h0003);
    chk("flush_flag", flag, 3'b000);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk($sformatf("flush_quiet_%0d", j), out_valid, 1'b0);
    end
    issue(4'h2, 16'h0002, 16'h0003);
    tick();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_out", out, 16'h0005);

    // asynchronous reset in the middle of a MUL
    issue(4'hD, 16'h0003, 16'h0004);
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", out, 16'h0);
    chk("rst_mid_flag", flag, 3'b000);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("rst_quiet_%0d", j), out_valid, 1'b0);
    end
    chk("rst_quiet_out", out, 16'h0);

    // randomized ops against the reference model
    exp_out  = 16'h0;
    exp_flag = 3'b000;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) in2 = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) in1 = 16'($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
      flag_load = ($urandom_range(0, 7) == 0);
      flag_in   = 3'($urandom);
      chk("rnd_ready", in_ready, 1'b1);
      if (op != 4'hD) begin
        model(op, in1, in2, exp_flag, exp_out, v, r, f);
        exp_out  = r;
        exp_flag = flag_load ? flag_in : f;
        tick();
        chk("rnd_valid", out_valid, v);
      end else begin
        model(op, in1, in2, exp_flag, exp_out, v, r, f);
        exp_flag = flag_load ? flag_in : exp_flag;
        tick();
        flag_load = 1'b0;
        chk("rnd_mul_accept_valid", out_valid, 1'b0);
        chk("rnd_mul_accept_flag", flag, exp_flag);
        for (int j = 1; j <= 15; j++) begin
          issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
          in_valid = 1'($urandom);
          tick();
          chk("rnd_mul_ready", in_ready, 1'b0);
          chk("rnd_mul_busy_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        exp_out  = r;
        exp_flag = f;
        tick();
        chk("rnd_mul_valid", out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      flag_load = 1'b0;
      chk("rnd_out", out, exp_out);
      chk("rnd_flag", flag, exp_flag);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
